// File: rtl/ifetch_queue_bp.sv
// ifetch_queue_bp
//   Fetch unit with one outstanding ICache request, JAL/JALR/branch
//   pre-decode, branch prediction and a QDEPTH-entry instruction queue
//   feeding the issue stage.
//
//   Configuration macro: IFETCH_BHT_EN
//     defined   : dynamic 2-bit counter BHT indexed by pc[IDX_W+1:2]
//     undefined : static BTFN (taken iff branch offset is negative),
//                 upd_* inputs are ignored
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     rdy             global enable, low freezes all state
//     ic_req_*        fetch request (level, held until ic_resp_valid)
//     ic_resp_*       one-cycle fetch response
//     iq_*            queue head (valid/ready handshake, 0-cycle read)
//     rb_valid/rb_pc  redirect from ROB: flush queue, refetch at rb_pc
//     upd_*           conditional-branch resolution for the predictor
module ifetch_queue_bp #(
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter int          QDEPTH      = 4,
   parameter int          BHT_ENTRIES = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   output logic        ic_req_valid,
   output logic [31:0] ic_req_addr,
   input  logic        ic_resp_valid,
   input  logic [31:0] ic_resp_inst,
   output logic        iq_valid,
   input  logic        iq_ready,
   output logic [31:0] iq_inst,
   output logic [31:0] iq_pc,
   output logic        iq_pred_taken,
   input  logic        rb_valid,
   input  logic [31:0] rb_pc,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);
   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

   state_t             state, state_nxt;
   logic               req_nxt;
   logic [31:0]        fetch_pc;
   logic [31:0]        req_addr;
   logic               stall;
   logic [CNT_W-1:0]   count;
   logic [PTR_W-1:0]   head, tail;

   logic [31:0]        q_inst [QDEPTH];
   logic [31:0]        q_pc   [QDEPTH];
   logic               q_pred [QDEPTH];

   logic               issue, push, pop;
   logic               is_jal, is_jalr, is_br;
   logic signed [31:0] j_imm, b_imm;
   logic               pred_br, pred;
   logic [31:0]        next_pc;

   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] r;
      r = ctr;
      if (taken && ctr != 2'b11)
         r = ctr + 2'b01;
      else if (!taken && ctr != 2'b00)
         r = ctr - 2'b01;
      return r;
   endfunction

   // Pre-decode of the returning instruction
   assign is_jal  = (ic_resp_inst[6:0] == 7'b1101111);
   assign is_jalr = (ic_resp_inst[6:0] == 7'b1100111);
   assign is_br   = (ic_resp_inst[6:0] == 7'b1100011);
   assign j_imm   = {{11{ic_resp_inst[31]}}, ic_resp_inst[31], ic_resp_inst[19:12],
                     ic_resp_inst[20], ic_resp_inst[30:21], 1'b0};
   assign b_imm   = {{19{ic_resp_inst[31]}}, ic_resp_inst[31], ic_resp_inst[7],
                     ic_resp_inst[30:25], ic_resp_inst[11:8], 1'b0};

`ifdef IFETCH_BHT_EN
   logic [1:0] bht [BHT_ENTRIES];
   logic       unused_upd;

   assign unused_upd = ^{upd_pc[31:IDX_W+2], upd_pc[1:0]};
   // Combinational read of the old counter value, so a same-cycle update
   // to the same index is not visible to this lookup.
   assign pred_br = bht[fetch_pc[IDX_W+1:2]][1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++)
            bht[i] <= 2'b01;
      end else if (rdy && upd_valid) begin
         bht[upd_pc[IDX_W+1:2]] <= sat_update(bht[upd_pc[IDX_W+1:2]], upd_taken);
      end
   end
`else
   logic unused_upd;

   assign unused_upd = ^{upd_valid, upd_pc, upd_taken, sat_update(2'b00, 1'b0)};
   // Backward branches (negative offset) are assumed to be loops.
   assign pred_br = ic_resp_inst[31];
`endif

   assign pred = is_jal | (is_br & pred_br);

   always_comb begin
      next_pc = fetch_pc + 32'd4;
      if (is_jal)
         next_pc = fetch_pc + j_imm;
      else if (is_br && pred_br)
         next_pc = fetch_pc + b_imm;
   end

   // A redirect suppresses both a new issue and a same-cycle push.
   assign issue = (state == S_IDLE) && !stall && (count < CNT_W'(QDEPTH)) && !rb_valid;
   assign push  = (state == S_WAIT) && ic_resp_valid && !rb_valid;
   assign pop   = iq_valid && iq_ready && !rb_valid;

   always_comb begin
      state_nxt = state;
      req_nxt   = ic_req_valid;
      if (rb_valid) begin
         // The outstanding request stays visible while draining.
         if (state == S_WAIT && !ic_resp_valid) begin
            state_nxt = S_DRAIN;
         end else begin
            state_nxt = S_IDLE;
            req_nxt   = 1'b0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (issue) begin
                  state_nxt = S_WAIT;
                  req_nxt   = 1'b1;
               end
            end
            S_WAIT, S_DRAIN: begin
               if (ic_resp_valid) begin
                  state_nxt = S_IDLE;
                  req_nxt   = 1'b0;
               end
            end
            default: begin
               state_nxt = S_IDLE;
               req_nxt   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         ic_req_valid <= 1'b0;
         fetch_pc     <= RESET_PC;
         stall        <= 1'b0;
         count        <= '0;
         head         <= '0;
         tail         <= '0;
      end else if (rdy) begin
         state        <= state_nxt;
         ic_req_valid <= req_nxt;
         if (rb_valid) begin
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            fetch_pc <= rb_pc;
            stall    <= 1'b0;
         end else begin
            if (push) begin
               tail     <= tail + PTR_W'(1);
               fetch_pc <= next_pc;
               stall    <= is_jalr;
            end
            if (pop)
               head <= head + PTR_W'(1);
            if (push && !pop)
               count <= count + CNT_W'(1);
            else if (!push && pop)
               count <= count - CNT_W'(1);
         end
      end
   end

   // Queue storage and request address carry no reset; validity comes
   // from count and ic_req_valid.
   always_ff @(posedge clk) begin
      if (rdy) begin
         if (issue)
            req_addr <= fetch_pc;
         if (push) begin
            q_inst[tail] <= ic_resp_inst;
            q_pc[tail]   <= fetch_pc;
            q_pred[tail] <= pred;
         end
      end
   end

   assign ic_req_addr   = req_addr;
   assign iq_valid      = (count != '0);
   assign iq_inst       = q_inst[head];
   assign iq_pc         = q_pc[head];
   assign iq_pred_taken = q_pred[head];

endmodule
